// File: rtl/sensor_conditioner_pkg.sv
// Shared sizing and helpers for the track-sensor conditioning block.
package sensor_conditioner_pkg;

    localparam int unsigned NUM_SENSORS    = 6;
    localparam int unsigned ID_W           = 3;
    localparam int unsigned DEB_CYCLES_DEF = 16;

    // Channel index 0..NUM_SENSORS-1 maps to sensor ID 1..NUM_SENSORS; ID 0 means "no event".
    function automatic logic [ID_W-1:0] id_of(input int unsigned idx);
        return ID_W'(idx + 1);
    endfunction

endpackage

// File: rtl/sensor_conditioner_if.sv
// Sensor-ID event handshake: the conditioner drives valid/id, downstream drives ready.
interface sensor_conditioner_if;
    import sensor_conditioner_pkg::*;

    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_ready;

    modport master (output evt_valid, output evt_id, input evt_ready);
    modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/sensor_conditioner_debounce_channel.sv
// One sensor line: 2-FF synchroniser, stability counter, clean level and rise pulse.
module sensor_conditioner_debounce_channel #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean,
    output logic rise
);
    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser for the asynchronous raw line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Accept a level only after it has differed from clean for DEB_CYCLES samples; rise pulses with a 0->1 toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync == clean) begin
                cnt <= '0;
            end else if (cnt >= CNT_W'(DEB_CYCLES - 1)) begin
                cnt   <= '0;
                clean <= ~clean;
                rise  <= ~clean;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions raw track sensors and serialises debounced arrivals into one-at-a-time ID events.
module sensor_conditioner
    import sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SENSORS-1:0] s_raw,
    input  logic                   ovr_clr,
    output logic [NUM_SENSORS-1:0] s_clean,
    output logic [NUM_SENSORS-1:0] ovr_flag,
    sensor_conditioner_if.master   evt
);
    localparam int unsigned IDX_W = $clog2(NUM_SENSORS);

    logic [NUM_SENSORS-1:0] rise;
    logic [NUM_SENSORS-1:0] pend_q, pend_n;
    logic [NUM_SENSORS-1:0] ovr_n;
    logic [NUM_SENSORS-1:0] clr_mask;
    logic [IDX_W-1:0]       pick_idx;
    logic                   load;
    logic                   evt_valid_q, evt_valid_n;
    logic [ID_W-1:0]        evt_id_q, evt_id_n;

    // Per-channel conditioning.
    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_ch
        sensor_conditioner_debounce_channel #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .raw   (s_raw[g]),
            .clean (s_clean[g]),
            .rise  (rise[g])
        );
    end

    // Lowest-index pending channel wins.
    always_comb begin
        pick_idx = '0;
        for (int i = int'(NUM_SENSORS) - 1; i >= 0; i--) begin
            if (pend_q[i]) pick_idx = IDX_W'(i);
        end
    end

    // Event-register load/drain, pending update (set beats clear) and sticky overrun.
    always_comb begin
        clr_mask    = '0;
        evt_valid_n = evt_valid_q;
        evt_id_n    = evt_id_q;
        ovr_n       = ovr_flag;
        load        = (!evt_valid_q || evt.evt_ready) && (|pend_q);
        if (load) begin
            clr_mask[pick_idx] = 1'b1;
            evt_valid_n        = 1'b1;
            evt_id_n           = id_of(32'(pick_idx));
        end else if (evt.evt_ready) begin
            evt_valid_n = 1'b0;
            evt_id_n    = '0;
        end
        pend_n = (pend_q & ~clr_mask) | rise;
        if (ovr_clr) ovr_n = '0;
        ovr_n = ovr_n | (rise & pend_q & ~clr_mask);
    end

    // State registers for pending vector, event register and overrun flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            ovr_flag    <= '0;
        end else begin
            pend_q      <= pend_n;
            evt_valid_q <= evt_valid_n;
            evt_id_q    <= evt_id_n;
            ovr_flag    <= ovr_n;
        end
    end

    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_id    = evt_id_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner with DEB_CYCLES=4.
module tb_sensor_conditioner;
    import sensor_conditioner_pkg::*;

    localparam int unsigned DEB = 4;

    logic                   clk;
    logic                   rst;
    logic [NUM_SENSORS-1:0] s_raw;
    logic                   ovr_clr;
    logic [NUM_SENSORS-1:0] s_clean;
    logic [NUM_SENSORS-1:0] ovr_flag;

    sensor_conditioner_if evt_bus();

    sensor_conditioner #(.DEB_CYCLES(DEB)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_raw    (s_raw),
        .ovr_clr  (ovr_clr),
        .s_clean  (s_clean),
        .ovr_flag (ovr_flag),
        .evt      (evt_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int sb[$];

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Pop scoreboard on each handshake; gap returns cycles between the last two accepts.
    task automatic wait_events(input string name, input int n, input int budget, output int gap);
        int got;
        int cyc;
        int prev;
        int expd;
        got = 0; cyc = 0; prev = -1; gap = 0;
        while (got < n && cyc < budget) begin
            if (evt_bus.evt_valid && evt_bus.evt_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s_unexpected: got id=%0d, expected no event", name, evt_bus.evt_id);
                end else begin
                    expd = sb.pop_front();
                    if (evt_bus.evt_id !== ID_W'(expd)) begin
                        errors++;
                        $display("FAIL %s_id: got id=%0d, expected %0d", name, evt_bus.evt_id, expd);
                    end
                end
                if (prev >= 0) gap = cyc - prev;
                prev = cyc;
                got++;
            end
            step();
            cyc++;
        end
        if (got < n) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d events, expected %0d", name, got, n);
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int cyc;
        cyc = 0;
        while (!evt_bus.evt_valid && cyc < budget) begin
            step();
            cyc++;
        end
        checks++;
        if (evt_bus.evt_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid_timeout: got valid=%b, expected 1", name, evt_bus.evt_valid);
        end
    endtask

    task automatic expect_idle(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (evt_bus.evt_valid !== 1'b0 || evt_bus.evt_id !== '0) begin
                errors++;
                $display("FAIL %s_idle: got valid=%b id=%0d, expected valid=0 id=0",
                         name, evt_bus.evt_valid, evt_bus.evt_id);
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_raw = '0; ovr_clr = 1'b0; evt_bus.evt_ready = 1'b0;
        steps(2);
        checks++;
        if (s_clean !== '0 || ovr_flag !== '0 || evt_bus.evt_valid !== 1'b0 || evt_bus.evt_id !== '0) begin
            errors++;
            $display("FAIL reset: got clean=%b ovr=%b valid=%b id=%0d, expected all 0",
                     s_clean, ovr_flag, evt_bus.evt_valid, evt_bus.evt_id);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_glitch();
        evt_bus.evt_ready = 1'b1;
        s_raw[2] = 1'b1;
        steps(3);
        s_raw[2] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (s_clean !== '0 || evt_bus.evt_valid !== 1'b0 || ovr_flag !== '0) begin
                errors++;
                $display("FAIL glitch: got clean=%b valid=%b ovr=%b, expected 0",
                         s_clean, evt_bus.evt_valid, ovr_flag);
            end
            step();
        end
    endtask

    task automatic test_single();
        int gap;
        evt_bus.evt_ready = 1'b1;
        s_raw[2] = 1'b1;
        sb.push_back(3);
        steps(DEB + 1);
        checks++;
        if (s_clean[2] !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got clean[2]=%b, expected 0", s_clean[2]);
        end
        step();
        checks++;
        if (s_clean[2] !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: got clean[2]=%b, expected 1", s_clean[2]);
        end
        wait_events("single", 1, 10, gap);
        expect_idle("single_drop", 3);
        s_raw[2] = 1'b0;
        expect_idle("single_fall", 10);
    endtask

    task automatic test_back_to_back();
        int gap;
        evt_bus.evt_ready = 1'b1;
        s_raw[1] = 1'b1;
        s_raw[4] = 1'b1;
        sb.push_back(2);
        sb.push_back(5);
        wait_events("b2b", 2, 20, gap);
        checks++;
        if (gap !== 1) begin
            errors++;
            $display("FAIL b2b_gap: got %0d cycles, expected 1", gap);
        end
        expect_idle("b2b_drop", 3);
        s_raw[1] = 1'b0;
        s_raw[4] = 1'b0;
        steps(10);
    endtask

    task automatic test_hold();
        int gap;
        evt_bus.evt_ready = 1'b0;
        s_raw[0] = 1'b1;
        sb.push_back(1);
        wait_valid("hold", 15);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_id !== ID_W'(sb[0])) begin
                errors++;
                $display("FAIL hold_stable: got valid=%b id=%0d, expected valid=1 id=%0d",
                         evt_bus.evt_valid, evt_bus.evt_id, sb[0]);
            end
            step();
        end
        evt_bus.evt_ready = 1'b1;
        wait_events("hold", 1, 2, gap);
        evt_bus.evt_ready = 1'b0;
        expect_idle("hold_single", 5);
        s_raw[0] = 1'b0;
        steps(10);
    endtask

    task automatic test_overrun();
        int gap;
        evt_bus.evt_ready = 1'b0;
        s_raw[0] = 1'b1;
        sb.push_back(1);
        wait_valid("ovr_hold", 15);
        for (int p = 0; p < 2; p++) begin
            s_raw[3] = 1'b1;
            steps(8);
            s_raw[3] = 1'b0;
            steps(8);
        end
        sb.push_back(4);
        checks++;
        if (ovr_flag !== 6'b001000) begin
            errors++;
            $display("FAIL ovr_set: got ovr=%b, expected 001000", ovr_flag);
        end
        evt_bus.evt_ready = 1'b1;
        wait_events("ovr", 2, 10, gap);
        expect_idle("ovr_merge", 10);
        checks++;
        if (ovr_flag !== 6'b001000) begin
            errors++;
            $display("FAIL ovr_sticky: got ovr=%b, expected 001000", ovr_flag);
        end
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        checks++;
        if (ovr_flag !== '0) begin
            errors++;
            $display("FAIL ovr_clr: got ovr=%b, expected 0", ovr_flag);
        end
    endtask

    task automatic test_reset_mid();
        int gap;
        evt_bus.evt_ready = 1'b0;
        s_raw[1] = 1'b1;
        wait_valid("rstmid_hold", 15);
        s_raw[5] = 1'b1;
        steps(4);
        rst = 1'b1;
        s_raw[0] = 1'b0;
        s_raw[1] = 1'b0;
        #1;
        checks++;
        if (s_clean !== '0 || ovr_flag !== '0 || evt_bus.evt_valid !== 1'b0 || evt_bus.evt_id !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got clean=%b ovr=%b valid=%b id=%0d, expected all 0",
                     s_clean, ovr_flag, evt_bus.evt_valid, evt_bus.evt_id);
        end
        steps(2);
        rst = 1'b0;
        steps(DEB + 1);
        checks++;
        if (s_clean[5] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_early: got clean[5]=%b, expected 0", s_clean[5]);
        end
        step();
        checks++;
        if (s_clean[5] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_latency: got clean[5]=%b, expected 1", s_clean[5]);
        end
        evt_bus.evt_ready = 1'b1;
        sb.push_back(6);
        wait_events("rstmid", 1, 10, gap);
        expect_idle("rstmid_noreplay", 15);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single();
        test_back_to_back();
        test_hold();
        test_overrun();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: got %0d undelivered, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
